regbank_arbiter: RTL

//   Two-requester round-robin arbiter and access sequencer for the 16x8 register bank.

---
 rtl/regbank_arbiter_if.sv | 33 +++
 rtl/regbank_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/regbank_arbiter_if.sv
// regbank_arbiter_if
//   One requester channel of the register-bank arbiter.
//   Ports (signals):
//     req    requester -> arbiter  access request (level, held until gnt)
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  target register
//     wdata  requester -> arbiter  write data
//     gnt    arbiter -> requester  op is on the bank this cycle (1-cycle pulse)
//     done   arbiter -> requester  op complete (1-cycle pulse)
//     rdata  arbiter -> requester  last read result, held until next read
//   Modports: master = requester side, slave = arbiter side.
interface regbank_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );
endinterface

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Two-requester round-robin arbiter and access sequencer for a 16x8
//   register bank. Serialises one read or write at a time (IDLE -> ACCESS ->
//   RESP), captures read data per requester and pulses gnt/done.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     a, b        requester channels (regbank_arbiter_if.slave)
//     bank_rd     bank read enable
//     bank_wr     bank write enable (gated by rst combinationally)
//     bank_addr   bank address (holds op register)
//     bank_wdata  bank write data (holds op register)
//     bank_rdata  bank combinational read data
//   Parameters: DATA_W, ADDR_W, FAIR (1 = round-robin on contention, 0 = A wins)
module regbank_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    regbank_arbiter_if.slave  a,
    regbank_arbiter_if.slave  b,
    output logic              bank_rd,
    output logic              bank_wr,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              pick_b;

    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              owner_b;
    logic              last_b;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Next-state and output decode. Requests are only looked at in IDLE;
    // on contention FAIR picks whoever was not granted last.
    // bank_wr is masked by rst directly so a write caught by reset in ACCESS
    // never reaches the bank.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        pick_b     = 1'b0;
        a.gnt      = 1'b0;
        a.done     = 1'b0;
        b.gnt      = 1'b0;
        b.done     = 1'b0;
        bank_rd    = 1'b0;
        bank_wr    = 1'b0;
        bank_addr  = op_addr;
        bank_wdata = op_wdata;
        a.rdata    = a_rdata_q;
        b.rdata    = b_rdata_q;

        case (state)
            IDLE: begin
                if (a.req || b.req) begin
                    accept     = 1'b1;
                    next_state = ACCESS;
                    if (a.req && b.req) begin
                        pick_b = FAIR ? ~last_b : 1'b0;
                    end else begin
                        pick_b = b.req;
                    end
                end
            end
            ACCESS: begin
                next_state = RESP;
                a.gnt      = ~owner_b;
                b.gnt      = owner_b;
                bank_rd    = ~op_we;
                bank_wr    = op_we & ~rst;
            end
            RESP: begin
                next_state = IDLE;
                a.done     = ~owner_b;
                b.done     = owner_b;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, op registers, grant pointer and per-requester read data.
    // Read data is captured on the edge that leaves ACCESS, so it is valid
    // together with done in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            owner_b   <= 1'b0;
            last_b    <= 1'b1;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                owner_b  <= pick_b;
                last_b   <= pick_b;
                op_we    <= pick_b ? b.we    : a.we;
                op_addr  <= pick_b ? b.addr  : a.addr;
                op_wdata <= pick_b ? b.wdata : a.wdata;
            end
            if (state == ACCESS && !op_we) begin
                if (owner_b) begin
                    b_rdata_q <= bank_rdata;
                end else begin
                    a_rdata_q <= bank_rdata;
                end
            end
        end
    end

endmodule
